// File: rtl/rv32i_pkg.sv
// Shared RV32I core types and constants.
// Fetch entries bundle a PC with the instruction word read at that PC.
// No timing or flow control lives here.
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetch entries, with synchronous flush.
// Latency: a pushed entry is visible at the head one edge later.
// Backpressure: the caller gates push on count/pop; flush overrides push and pop.
module fetch_buffer
    import rv32i_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_dat,
    output logic [1:0]   count,
    output fetch_entry_t head_dat
);

    fetch_entry_t entry_q [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
        end else if (flush) begin
            // Stale contents stay in place; count == 0 hides them.
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                entry_q[wr_ptr] <= push_dat;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_dat = entry_q[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: owns the PC, captures the instruction word, buffers it for decode.
// Latency: PC presented in cycle N appears at the buffer head in cycle N+1.
// Backpressure: PC freezes while the 2-entry buffer is full and decode is not accepting.
module instruction_fetch
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int          BUF_DEPTH    = 2
) (
    input  logic        Clk_Core,
    input  logic        Rst_Core,
    output logic [31:0] Program_Count,
    input  logic [31:0] Instruction,
    input  logic        Redirect_Valid,
    input  logic [31:0] Redirect_Target,
    output logic        Fetch_Valid,
    input  logic        Fetch_Ready,
    output logic [31:0] Fetch_Instr,
    output logic [31:0] Fetch_PC,
    output logic        Misalign_Err
);

    localparam logic [1:0] FULL_COUNT = 2'(BUF_DEPTH);

    logic [XLEN-1:0] pc;
    logic            misalign_q;
    logic [1:0]      count;
    logic            push;
    logic            pop;
    fetch_entry_t    push_dat;
    fetch_entry_t    head_dat;

    assign Program_Count = pc;
    assign Fetch_Valid   = (count != 2'd0);
    assign pop           = Fetch_Valid && Fetch_Ready;
    // A full buffer still accepts when decode drains the head in the same cycle.
    assign push          = !Redirect_Valid && ((count < FULL_COUNT) || pop);
    assign push_dat      = '{pc: pc, instr: Instruction};

    always_ff @(posedge Clk_Core or posedge Rst_Core) begin
        if (Rst_Core) begin
            pc <= RESET_VECTOR;
        end else if (Redirect_Valid) begin
            pc <= {Redirect_Target[31:2], 2'b00};
        end else if (push) begin
            pc <= pc + INSTR_BYTES;
        end
    end

    always_ff @(posedge Clk_Core or posedge Rst_Core) begin
        if (Rst_Core) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= Redirect_Valid && (|Redirect_Target[1:0]);
        end
    end

    assign Misalign_Err = misalign_q;

    fetch_buffer u_fetch_buffer (
        .clk      (Clk_Core),
        .rst      (Rst_Core),
        .push     (push),
        .pop      (pop),
        .flush    (Redirect_Valid),
        .push_dat (push_dat),
        .count    (count),
        .head_dat (head_dat)
    );

    assign Fetch_Instr = head_dat.instr;
    assign Fetch_PC    = head_dat.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a PC scoreboard on the decode handshake.
module tb_instruction_fetch;

    logic        Clk_Core = 1'b0;
    logic        Rst_Core;
    logic [31:0] Program_Count;
    logic [31:0] Instruction;
    logic        Redirect_Valid;
    logic [31:0] Redirect_Target;
    logic        Fetch_Valid;
    logic        Fetch_Ready;
    logic [31:0] Fetch_Instr;
    logic [31:0] Fetch_PC;
    logic        Misalign_Err;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q [$];

    always #5 Clk_Core = ~Clk_Core;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign Instruction = mem_word(Program_Count);

    instruction_fetch #(.RESET_VECTOR(32'h0000_0100), .BUF_DEPTH(2)) dut (
        .Clk_Core        (Clk_Core),
        .Rst_Core        (Rst_Core),
        .Program_Count   (Program_Count),
        .Instruction     (Instruction),
        .Redirect_Valid  (Redirect_Valid),
        .Redirect_Target (Redirect_Target),
        .Fetch_Valid     (Fetch_Valid),
        .Fetch_Ready     (Fetch_Ready),
        .Fetch_Instr     (Fetch_Instr),
        .Fetch_PC        (Fetch_PC),
        .Misalign_Err    (Misalign_Err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge Clk_Core);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pc"},       Program_Count, 32'h0000_0100);
        chk({tag, "_valid"},    {31'd0, Fetch_Valid}, 32'd0);
        chk({tag, "_fpc"},      Fetch_PC, 32'd0);
        chk({tag, "_finstr"},   Fetch_Instr, 32'd0);
        chk({tag, "_misalign"}, {31'd0, Misalign_Err}, 32'd0);
    endtask

    // Monitor: every completed handshake must match the next expected PC.
    always @(negedge Clk_Core) begin
        if (!Rst_Core && Fetch_Valid && Fetch_Ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pop: got pc %h, expected no delivery (t=%0t)", Fetch_PC, $time);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("pop_pc", Fetch_PC, e);
                chk("pop_instr", Fetch_Instr, mem_word(e));
            end
        end
    end

    initial begin
        Rst_Core        = 1'b1;
        Redirect_Valid  = 1'b0;
        Redirect_Target = 32'd0;
        Fetch_Ready     = 1'b1;

        // Reset and streaming from the reset vector.
        #12;
        chk_reset_outputs("reset");
        Rst_Core = 1'b0;
        cyc();                              // cycle 0
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        chk("first_valid", {31'd0, Fetch_Valid}, 32'd1);
        cyc();
        cyc();
        cyc();
        Fetch_Ready = 1'b0;
        chk("stream_pc", Program_Count, 32'h110);

        // Asynchronous reset between edges, then backpressure from empty.
        #2;
        Rst_Core = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        cyc();
        #2;
        Rst_Core = 1'b0;
        cyc();                              // cycle 0: 0x100 captured
        chk("bp_instr0", Fetch_Instr, mem_word(32'h100));
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("bp_pc_frozen", Program_Count, 32'h108);
            chk("bp_head_pc", Fetch_PC, 32'h100);
            chk("bp_head_instr", Fetch_Instr, mem_word(32'h100));
        end
        Fetch_Ready = 1'b1;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        cyc();
        chk("bp_nogap1", {Fetch_Valid, Fetch_PC[30:0]}, {1'b1, 31'h104});
        cyc();
        chk("bp_nogap2", {Fetch_Valid, Fetch_PC[30:0]}, {1'b1, 31'h108});
        cyc();
        Fetch_Ready = 1'b0;

        // Redirect with two entries buffered.
        Redirect_Valid  = 1'b1;
        Redirect_Target = 32'h40;
        cyc();
        Redirect_Valid = 1'b0;
        chk("redir_valid", {31'd0, Fetch_Valid}, 32'd0);
        chk("redir_pc", Program_Count, 32'h40);
        chk("redir_misalign", {31'd0, Misalign_Err}, 32'd0);
        cyc();
        chk("redir_fpc", {Fetch_Valid, Fetch_PC[30:0]}, {1'b1, 31'h40});

        // Redirect in the same cycle as a pop.
        Fetch_Ready = 1'b1;
        exp_q.push_back(32'h40);
        Redirect_Valid  = 1'b1;
        Redirect_Target = 32'h20;
        cyc();
        Redirect_Valid = 1'b0;
        Fetch_Ready    = 1'b0;
        chk("rpop_valid", {31'd0, Fetch_Valid}, 32'd0);
        chk("rpop_pc", Program_Count, 32'h20);
        cyc();
        chk("rpop_fpc", {Fetch_Valid, Fetch_PC[30:0]}, {1'b1, 31'h20});

        // Misaligned redirect.
        Redirect_Valid  = 1'b1;
        Redirect_Target = 32'h43;
        cyc();
        Redirect_Valid = 1'b0;
        chk("mis_pulse", {31'd0, Misalign_Err}, 32'd1);
        chk("mis_pc", Program_Count, 32'h40);
        chk("mis_valid", {31'd0, Fetch_Valid}, 32'd0);
        cyc();
        chk("mis_pulse_end", {31'd0, Misalign_Err}, 32'd0);
        chk("mis_fpc", {Fetch_Valid, Fetch_PC[30:0]}, {1'b1, 31'h40});

        // PC wrap at the top of the address space.
        Redirect_Valid  = 1'b1;
        Redirect_Target = 32'hFFFF_FFFC;
        cyc();
        Redirect_Valid = 1'b0;
        Fetch_Ready    = 1'b1;
        exp_q.push_back(32'hFFFF_FFFC);
        chk("wrap_pc_top", Program_Count, 32'hFFFF_FFFC);
        cyc();
        chk("wrap_pc_zero", Program_Count, 32'h0);
        cyc();
        exp_q.push_back(32'h0);
        chk("wrap_fpc", Fetch_PC, 32'h0);
        cyc();

        // Reset mid-stream with an entry at the head.
        #2;
        Rst_Core = 1'b1;
        #1;
        chk_reset_outputs("async_rst2");
        cyc();
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
